// File: rtl/ep2_pkg.sv
// Shared definitions for the EP2 packet router: header layout, FSM encoding
// and a small saturating-increment helper.
package ep2_pkg;

    localparam logic [3:0] SYNC_NIBBLE = 4'h5;

    localparam int HDR_SYNC_MSB = 7;
    localparam int HDR_SYNC_LSB = 4;
    localparam int HDR_PORT_MSB = 3;
    localparam int HDR_PORT_LSB = 0;

    typedef enum logic [2:0] {
        HDR     = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        PAYLOAD = 3'd3,
        DISCARD = 3'd4
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ep2_port_counter.sv
// One 32-bit wrapping byte counter; wrap is intentional because the consumer
// only ever looks at differences between samples.
module ep2_port_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ep2_packet_router.sv
// Parses the EP2 byte stream into header/length/payload and steers payload
// bytes into one of NUM_PORTS write FIFOs, keeping a byte count per port.
module ep2_packet_router #(
    parameter int         NUM_PORTS   = 4,
    parameter logic [3:0] SYNC_NIBBLE = 4'h5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              fifo_wr_data,
    output logic [NUM_PORTS-1:0]    fifo_wr_en,
    input  logic [NUM_PORTS-1:0]    fifo_afull,
    output logic [32*NUM_PORTS-1:0] byte_counts,
    output logic [15:0]             sync_err_count,
    output logic [15:0]             bad_port_count,
    output logic                    busy
);
    import ep2_pkg::*;

    localparam logic [4:0] NUM_PORTS_W = 5'(NUM_PORTS);

    state_e               state_q;
    logic [3:0]           port_q;
    logic [7:0]           len_hi_q;
    logic [15:0]          remaining_q;
    logic [7:0]           wr_data_q;
    logic [NUM_PORTS-1:0] wr_en_q;
    logic [15:0]          sync_err_q;
    logic [15:0]          bad_port_q;

    logic [NUM_PORTS-1:0] port_hit;
    logic                 afull_sel;
    logic                 accept;
    logic                 payload_accept;
    logic                 port_in_range;
    logic [15:0]          length_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [31:0] cnt;

            assign port_hit[gi] = (port_q == 4'(gi));

            // Enable on the accepting edge so the count moves with fifo_wr_en.
            ep2_port_counter u_cnt (
                .clk     (clk),
                .reset   (reset),
                .en_i    (payload_accept && port_hit[gi]),
                .count_o (cnt)
            );

            assign byte_counts[32*gi +: 32] = cnt;
        end
    endgenerate

    always_comb begin
        afull_sel = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_hit[p]) begin
                afull_sel = fifo_afull[p];
            end
        end
    end

    // in_ready is held low during reset so every output reads 0 there.
    assign in_ready       = ~reset & ((state_q == PAYLOAD) ? ~afull_sel : 1'b1);
    assign accept         = in_valid & in_ready;
    assign payload_accept = accept && (state_q == PAYLOAD);
    assign port_in_range  = ({1'b0, port_q} < NUM_PORTS_W);
    assign length_w       = {len_hi_q, in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HDR;
            port_q      <= '0;
            len_hi_q    <= '0;
            remaining_q <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= '0;
            sync_err_q  <= '0;
            bad_port_q  <= '0;
        end else begin
            wr_en_q <= '0;
            if (payload_accept) begin
                wr_en_q   <= port_hit;
                wr_data_q <= in_data;
            end
            if (accept) begin
                case (state_q)
                    HDR: begin
                        if (in_data[HDR_SYNC_MSB:HDR_SYNC_LSB] != SYNC_NIBBLE) begin
                            sync_err_q <= sat_inc16(sync_err_q);
                        end else begin
                            port_q  <= in_data[HDR_PORT_MSB:HDR_PORT_LSB];
                            state_q <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        len_hi_q <= in_data;
                        state_q  <= LEN_LO;
                    end
                    LEN_LO: begin
                        remaining_q <= length_w;
                        if (length_w == 16'd0) begin
                            state_q <= HDR;
                        end else if (!port_in_range) begin
                            bad_port_q <= sat_inc16(bad_port_q);
                            state_q    <= DISCARD;
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end
                    PAYLOAD, DISCARD: begin
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_q <= HDR;
                        end
                    end
                    default: state_q <= HDR;
                endcase
            end
        end
    end

    assign fifo_wr_data   = wr_data_q;
    assign fifo_wr_en     = wr_en_q;
    assign sync_err_count = sync_err_q;
    assign bad_port_count = bad_port_q;
    assign busy           = (state_q != HDR);

endmodule
